// File: rtl/sub_lane_serial.sv
// Lane-serial inverse of the 1024-bit feed-forward lane adder: res lane k = a_k - b_k (mod 2^64) when d[1:0]==0, else a.
// Optional build macro SUB_FASTPATH_EN: pass-through words bypass the lane-serial RUN phase.
module sub_lane_serial #(
  parameter int LANES_PER_CYC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    d,
  input  logic [1023:0] a,
  input  logic [1023:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1023:0] res
);
  localparam int N = 16 / LANES_PER_CYC;
  localparam int W = 64 * LANES_PER_CYC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_PASS = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [1023:0] a_q, a_d;
  logic [1023:0] b_q, b_d;
  logic [1023:0] res_q, res_d;
  logic          sub_en_q, sub_en_d;
  logic [W-1:0]  chunk_s;
  logic          d_unused_s;

  function automatic logic [W-1:0] lane_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic en);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int l = 0; l < LANES_PER_CYC; l++) begin
      r[64*l +: 64] = en ? (x[64*l +: 64] - y[64*l +: 64]) : x[64*l +: 64];
    end
    return r;
  endfunction

  // Only the low two bits of the round index select the operation.
  assign d_unused_s = ^d[7:2];

  // a_q/b_q shift left each RUN cycle, so the lanes being processed always sit at the top.
  assign chunk_s   = lane_sub(a_q[1023 -: W], b_q[1023 -: W], sub_en_q);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    sub_en_d = sub_en_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          sub_en_d = (d[1:0] == 2'b00);
          cnt_d    = 5'd0;
`ifdef SUB_FASTPATH_EN
          state_d  = (d[1:0] == 2'b00) ? S_RUN : S_PASS;
`else
          state_d  = S_RUN;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        res_d[1023 - W*int'(cnt_q) -: W] = chunk_s;
        a_d   = a_q << W;
        b_d   = b_q << W;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
`ifdef SUB_FASTPATH_EN
      S_PASS: begin
        res_d   = a_q;
        state_d = S_DONE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and data registers; reset discards any in-flight word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      a_q      <= {1024{1'b0}};
      b_q      <= {1024{1'b0}};
      res_q    <= {1024{1'b0}};
      sub_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      sub_en_q <= sub_en_d;
    end
  end
endmodule

// File: tb/tb_sub_lane_serial.sv
// Self-checking bench for sub_lane_serial: directed steps on an L=4 instance, random round-trip on L=1..16.
module tb_sub_lane_serial;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SUB_FASTPATH_EN
  localparam int LAT_PASS = 1;
`else
  localparam int LAT_PASS = 4;
`endif

  logic          rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]    d;
  logic [1023:0] a, b, res;

  logic          rt_in_valid, rt_out_ready;
  logic [4:0]    rt_in_ready, rt_out_valid;
  logic [7:0]    rt_d;
  logic [1023:0] rt_a, rt_b;
  logic [1023:0] rt_res [5];

  int total = 0;
  int pass_cnt = 0;
  int cyc;
  logic [7:0]    wd;
  logic [1023:0] wa, wb, wexp, w2a, w2b, wsum;

  sub_lane_serial #(.LANES_PER_CYC(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .d(d), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  for (genvar g = 0; g < 5; g++) begin : g_rt
    sub_lane_serial #(.LANES_PER_CYC(1 << g)) u_rt (
      .clk(clk), .rst_n(rst_n), .in_valid(rt_in_valid), .in_ready(rt_in_ready[g]), .d(rt_d),
      .a(rt_a), .b(rt_b), .out_valid(rt_out_valid[g]), .out_ready(rt_out_ready), .res(rt_res[g])
    );
  end

  // Reference: sixteen independent 64-bit lanes, lane k at bits [1023-64k -: 64].
  function automatic logic [1023:0] lane_op(input logic [1023:0] x, input logic [1023:0] y,
                                            input bit sub);
    logic [1023:0] r;
    logic [63:0] xl, yl;
    r = {1024{1'b0}};
    for (int k = 0; k < 16; k++) begin
      xl = x[1023-64*k -: 64];
      yl = y[1023-64*k -: 64];
      r[1023-64*k -: 64] = sub ? xl - yl : xl + yl;
    end
    return r;
  endfunction

  function automatic logic [1023:0] ref_res(input logic [7:0] dd, input logic [1023:0] x,
                                            input logic [1023:0] y);
    return (dd % 8'd4 == 8'd0) ? lane_op(x, y, 1'b1) : x;
  endfunction

  function automatic logic [1023:0] rand_word();
    logic [1023:0] w;
    for (int i = 0; i < 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int k;
    k = 0;
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      for (int i = 15; i >= 0; i--) if (obs[1023-64*i -: 64] !== exp[1023-64*i -: 64]) k = i;
      $error("FAIL %s lane %0d: got %h, expected %h", tag, k, obs[1023-64*k -: 64],
             exp[1023-64*k -: 64]);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  // Present one word to the L=4 instance from IDLE; return cycles from accept edge to out_valid.
  task automatic send_main(input logic [7:0] dd, input logic [1023:0] aa, input logic [1023:0] bb,
                           output int n);
    in_valid = 1'b1; d = dd; a = aa; b = bb;
    chk("in_ready_idle", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; d = $urandom; a = rand_word(); b = rand_word();
    wait_out(n);
  endtask

  task automatic release_main();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = 8'd0; a = '0; b = '0;
    rt_in_valid = 1'b0; rt_out_ready = 1'b0; rt_d = 8'd0; rt_a = '0; rt_b = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_res", res, '0);
    rst_n = 1'b1;
    tick();

    // Reset two cycles into RUN
    in_valid = 1'b1; d = 8'h00; a = rand_word(); b = rand_word();
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrun_out_valid", out_valid, 1'b0);
    chk("midrun_res", res, '0);
    chk("midrun_in_ready", in_ready, 1'b1);
    repeat (8) tick();
    chk("midrun_no_stale", out_valid, 1'b0);

    // Wrap: 0 - 1 in every lane
    wa = '0;
    for (int k = 0; k < 16; k++) wb[1023-64*k -: 64] = 64'd1;
    send_main(8'h00, wa, wb, cyc);
    chk("wrap_latency", cyc, 4);
    chk("wrap_res", res, {1024{1'b1}});
    release_main();

    // Lane order
    for (int k = 0; k < 16; k++) begin
      wa[1023-64*k -: 64] = 64'(k + 100);
      wb[1023-64*k -: 64] = 64'(k);
    end
    for (int k = 0; k < 16; k++) wexp[1023-64*k -: 64] = 64'd100;
    send_main(8'h04, wa, wb, cyc);
    chk("order_latency", cyc, 4);
    chk("order_res", res, wexp);
    release_main();

    // Borrow in lane 15 must not reach lane 14
    wa = rand_word(); wb = rand_word();
    wa[63:0] = 64'd0;   wb[63:0] = 64'd1;
    wa[127:64] = 64'd5; wb[127:64] = 64'd3;
    send_main(8'h00, wa, wb, cyc);
    chk("borrow_res", res, ref_res(8'h00, wa, wb));
    chk("borrow_lane14", res[127:64], 64'd2);
    chk("borrow_lane15", res[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    release_main();

    // Pass-through and boundary round indices
    wa = rand_word(); wb = rand_word();
    send_main(8'h03, wa, wb, cyc);
    chk("pass03_latency", cyc, LAT_PASS);
    chk("pass03_res", res, wa);
    release_main();
    wa = rand_word(); wb = rand_word();
    send_main(8'hFF, wa, wb, cyc);
    chk("passFF_res", res, wa);
    release_main();
    wa = rand_word(); wb = rand_word();
    send_main(8'hFC, wa, wb, cyc);
    chk("subFC_latency", cyc, 4);
    chk("subFC_res", res, lane_op(wa, wb, 1'b1));
    release_main();

    // Backpressure with a second word waiting
    wa = rand_word(); wb = rand_word();
    wexp = ref_res(8'hFC, wa, wb);
    send_main(8'hFC, wa, wb, cyc);
    w2a = rand_word(); w2b = rand_word();
    in_valid = 1'b1; d = 8'hFF; a = w2a; b = w2b;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_res", res, wexp);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1'b1);
    chk("bp_idle_valid", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    chk("bp_next_latency", cyc, LAT_PASS);
    chk("bp_next_res", res, w2a);
    release_main();

    // Random words on the L=4 instance
    for (int n = 0; n < 20; n++) begin
      wd = 8'($urandom); wa = rand_word(); wb = rand_word();
      send_main(wd, wa, wb, cyc);
      chk("rand_latency", cyc, (wd[1:0] == 2'b00) ? 4 : LAT_PASS);
      chk("rand_res", res, ref_res(wd, wa, wb));
      release_main();
    end

    // Round-trip through the lane adder for every lane width
    for (int n = 0; n < 200; n++) begin
      wd = 8'($urandom); wa = rand_word(); wb = rand_word();
      wsum = lane_op(wa, wb, 1'b0);
      wexp = (wd[1:0] == 2'b00) ? wa : wsum;
      rt_d = wd; rt_a = wsum; rt_b = wb; rt_in_valid = 1'b1;
      chk("rt_in_ready", rt_in_ready, 5'b11111);
      tick();
      rt_in_valid = 1'b0;
      cyc = 0;
      while (rt_out_valid !== 5'b11111 && cyc < 64) begin
        tick();
        cyc++;
      end
      chk("rt_out_valid", rt_out_valid, 5'b11111);
      for (int g = 0; g < 5; g++) chk($sformatf("rt_L%0d", 1 << g), rt_res[g], wexp);
      rt_out_ready = 1'b1;
      tick();
      rt_out_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
